// File: rtl/regfile_pkg.sv
// Shared constants for the register file front-end controller.
// FSM encodings are plain localparams so older code can compare against them.
package regfile_pkg;

  localparam int RF_ADDR_W = 5;
  localparam logic [RF_ADDR_W-1:0] RF_ZERO_IDX = '0;

  typedef logic [1:0] state_t;

  localparam state_t IDLE        = 2'd0;
  localparam state_t DBG_RD_WAIT = 2'd1;
  localparam state_t CLEAR       = 2'd2;

endpackage

// File: rtl/regfile_ctrl.sv
// Register file front-end: arbitrates pipeline vs. debug access and sequences
// a bulk clear of x1..x(N-1), one register per cycle.
module regfile_ctrl
  import regfile_pkg::*;
#(
  parameter int REG_FILE_SIZE  = 32,
  parameter int REG_FILE_WIDTH = 32
) (
  input  logic                      I_clk,
  input  logic                      I_reset,
  input  logic [RF_ADDR_W-1:0]      I_cpu_rs1,
  input  logic [RF_ADDR_W-1:0]      I_cpu_rs2,
  input  logic [RF_ADDR_W-1:0]      I_cpu_rd,
  input  logic                      I_cpu_re,
  input  logic                      I_cpu_we,
  input  logic [REG_FILE_WIDTH-1:0] I_cpu_data,
  output logic                      O_cpu_stall,
  input  logic                      I_dbg_req,
  input  logic                      I_dbg_we,
  input  logic [RF_ADDR_W-1:0]      I_dbg_addr,
  input  logic [REG_FILE_WIDTH-1:0] I_dbg_wdata,
  output logic                      O_dbg_ack,
  output logic [REG_FILE_WIDTH-1:0] O_dbg_rdata,
  input  logic                      I_clr_req,
  output logic                      O_clr_busy,
  output logic [RF_ADDR_W-1:0]      O_rf_rs1,
  output logic [RF_ADDR_W-1:0]      O_rf_rs2,
  output logic [RF_ADDR_W-1:0]      O_rf_rd,
  output logic                      O_rf_re,
  output logic                      O_rf_we,
  output logic [REG_FILE_WIDTH-1:0] O_rf_data,
  input  logic [REG_FILE_WIDTH-1:0] I_rf_regval1
);

  localparam logic [RF_ADDR_W-1:0] CLR_FIRST = RF_ADDR_W'(1);
  localparam logic [RF_ADDR_W-1:0] CLR_LAST  = RF_ADDR_W'(REG_FILE_SIZE - 1);

  state_t                      state;
  state_t                      next_state;
  logic                        clr_pend;
  logic                        cpu_turn;
  logic [RF_ADDR_W-1:0]        clr_cnt;
  logic                        dbg_rd_zero;
  logic                        dbg_grant;
  logic                        cpu_pass;
  logic                        enter_clear;

  assign enter_clear = (state == IDLE) && clr_pend;
  assign O_clr_busy  = clr_pend || (state == CLEAR);

  // Grant order in IDLE: pending clear, then debug (unless the CPU is owed a turn), then CPU.
  always_comb begin
    next_state  = state;
    dbg_grant   = 1'b0;
    cpu_pass    = 1'b0;
    O_rf_rs1    = I_cpu_rs1;
    O_rf_rs2    = I_cpu_rs2;
    O_rf_rd     = I_cpu_rd;
    O_rf_re     = 1'b0;
    O_rf_we     = 1'b0;
    O_rf_data   = I_cpu_data;
    O_cpu_stall = 1'b1;
    case (state)
      IDLE: begin
        if (clr_pend) begin
          next_state = CLEAR;
        end else if (I_dbg_req && !cpu_turn) begin
          dbg_grant = 1'b1;
          if (I_dbg_we) begin
            O_rf_rd   = I_dbg_addr;
            O_rf_we   = 1'b1;
            O_rf_data = I_dbg_wdata;
          end else begin
            O_rf_rs1   = I_dbg_addr;
            O_rf_rs2   = I_dbg_addr;
            O_rf_re    = 1'b1;
            next_state = DBG_RD_WAIT;
          end
        end else begin
          cpu_pass    = 1'b1;
          O_rf_re     = I_cpu_re;
          O_rf_we     = I_cpu_we;
          O_cpu_stall = 1'b0;
        end
      end
      DBG_RD_WAIT: begin
        next_state = IDLE;
      end
      CLEAR: begin
        O_rf_we   = 1'b1;
        O_rf_rd   = clr_cnt;
        O_rf_data = '0;
        if (clr_cnt == CLR_LAST) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    if (I_reset) begin
      O_rf_we     = 1'b0;
      O_rf_re     = 1'b0;
      O_cpu_stall = 1'b1;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state       <= IDLE;
      clr_pend    <= 1'b0;
      cpu_turn    <= 1'b0;
      clr_cnt     <= CLR_FIRST;
      dbg_rd_zero <= 1'b0;
      O_dbg_ack   <= 1'b0;
      O_dbg_rdata <= '0;
    end else begin
      state    <= next_state;
      // A request arriving on the same cycle the clear starts must not be lost.
      clr_pend <= I_clr_req || (clr_pend && !enter_clear);
      if (dbg_grant) begin
        cpu_turn <= 1'b1;
      end else if ((state == IDLE) && (cpu_pass || (!I_cpu_re && !I_cpu_we))) begin
        cpu_turn <= 1'b0;
      end
      if (state == CLEAR) begin
        clr_cnt <= (clr_cnt == CLR_LAST) ? CLR_FIRST : clr_cnt + 1'b1;
      end
      if (dbg_grant && !I_dbg_we) begin
        dbg_rd_zero <= (I_dbg_addr == RF_ZERO_IDX);
      end
      O_dbg_ack <= (dbg_grant && I_dbg_we) || (state == DBG_RD_WAIT);
      if (state == DBG_RD_WAIT) begin
        O_dbg_rdata <= dbg_rd_zero ? '0 : I_rf_regval1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Self-checking bench for regfile_ctrl with a behavioural register file attached.
module tb_regfile_ctrl;

  localparam int W = 32;

  logic          I_clk = 1'b0;
  logic          I_reset;
  logic [4:0]    I_cpu_rs1, I_cpu_rs2, I_cpu_rd;
  logic          I_cpu_re, I_cpu_we;
  logic [W-1:0]  I_cpu_data;
  logic          O_cpu_stall;
  logic          I_dbg_req, I_dbg_we;
  logic [4:0]    I_dbg_addr;
  logic [W-1:0]  I_dbg_wdata;
  logic          O_dbg_ack;
  logic [W-1:0]  O_dbg_rdata;
  logic          I_clr_req;
  logic          O_clr_busy;
  logic [4:0]    O_rf_rs1, O_rf_rs2, O_rf_rd;
  logic          O_rf_re, O_rf_we;
  logic [W-1:0]  O_rf_data;
  logic [W-1:0]  I_rf_regval1;

  logic [W-1:0]  rf_mem [32];
  logic [W-1:0]  shadow [32];
  logic [W-1:0]  cpu_q [$];
  logic [W-1:0]  dbg_q [$];
  int            n_checks = 0;
  int            n_fail   = 0;

  always #5 I_clk = ~I_clk;

  regfile_ctrl #(.REG_FILE_SIZE(32), .REG_FILE_WIDTH(W)) dut (
    .I_clk(I_clk), .I_reset(I_reset),
    .I_cpu_rs1(I_cpu_rs1), .I_cpu_rs2(I_cpu_rs2), .I_cpu_rd(I_cpu_rd),
    .I_cpu_re(I_cpu_re), .I_cpu_we(I_cpu_we), .I_cpu_data(I_cpu_data),
    .O_cpu_stall(O_cpu_stall),
    .I_dbg_req(I_dbg_req), .I_dbg_we(I_dbg_we), .I_dbg_addr(I_dbg_addr),
    .I_dbg_wdata(I_dbg_wdata), .O_dbg_ack(O_dbg_ack), .O_dbg_rdata(O_dbg_rdata),
    .I_clr_req(I_clr_req), .O_clr_busy(O_clr_busy),
    .O_rf_rs1(O_rf_rs1), .O_rf_rs2(O_rf_rs2), .O_rf_rd(O_rf_rd),
    .O_rf_re(O_rf_re), .O_rf_we(O_rf_we), .O_rf_data(O_rf_data),
    .I_rf_regval1(I_rf_regval1)
  );

  // Neighbouring register file: x0 hard-zero, synchronous read on port 1.
  always @(posedge I_clk) begin
    if (O_rf_we && O_rf_rd != 5'd0) rf_mem[O_rf_rd] <= O_rf_data;
    if (O_rf_re) I_rf_regval1 <= (O_rf_rs1 == 5'd0) ? '0 : rf_mem[O_rf_rs1];
  end

  task automatic cpu_write(input logic [4:0] addr, input logic [W-1:0] data);
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge I_clk);
      I_cpu_we = 1'b1; I_cpu_re = 1'b0; I_cpu_rd = addr; I_cpu_data = data;
      #1;
      if (!O_cpu_stall) done = 1'b1;
    end
    @(posedge I_clk); #1;
    I_cpu_we = 1'b0;
    if (!done) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL cpu_write x%0d: stalled past budget", addr);
    end else if (addr != 5'd0) begin
      shadow[addr] = data;
    end
  endtask

  task automatic cpu_read(input logic [4:0] addr);
    bit done = 1'b0;
    logic [W-1:0] exp;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge I_clk);
      I_cpu_re = 1'b1; I_cpu_we = 1'b0; I_cpu_rs1 = addr; I_cpu_rs2 = addr;
      #1;
      if (!O_cpu_stall) begin
        done = 1'b1;
        cpu_q.push_back(shadow[addr]);
      end
    end
    @(posedge I_clk); #1;
    I_cpu_re = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("[TB] FAIL cpu_read x%0d: stalled past budget", addr);
    end else begin
      exp = cpu_q.pop_front();
      if (I_rf_regval1 !== exp) begin
        n_fail++;
        $display("[TB] FAIL cpu_read x%0d: got %h expected %h", addr, I_rf_regval1, exp);
      end
    end
  endtask

  task automatic dbg_access(input bit we, input logic [4:0] addr, input logic [W-1:0] wdata,
                            input int exp_lat);
    int lat = 0;
    bit got = 1'b0;
    logic [W-1:0] exp;
    @(negedge I_clk);
    I_dbg_req = 1'b1; I_dbg_we = we; I_dbg_addr = addr; I_dbg_wdata = wdata;
    if (!we) dbg_q.push_back(shadow[addr]);
    else if (addr != 5'd0) shadow[addr] = wdata;
    while (!got && lat < 60) begin
      @(negedge I_clk); #1;
      lat++;
      if (O_dbg_ack) got = 1'b1;
    end
    I_dbg_req = 1'b0;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("[TB] FAIL dbg_ack x%0d: no ack within %0d cycles", addr, lat);
    end else begin
      if (lat != exp_lat) begin
        n_fail++;
        $display("[TB] FAIL dbg_latency x%0d: got %0d expected %0d", addr, lat, exp_lat);
      end
      if (!we) begin
        exp = dbg_q.pop_front();
        n_checks++;
        if (O_dbg_rdata !== exp) begin
          n_fail++;
          $display("[TB] FAIL dbg_rdata x%0d: got %h expected %h", addr, O_dbg_rdata, exp);
        end
      end
    end
  endtask

  task automatic test_reset();
    I_reset = 1'b1;
    I_cpu_re = 1'b1; I_cpu_we = 1'b1; I_cpu_rs1 = 5'd1; I_cpu_rs2 = 5'd1;
    I_cpu_rd = 5'd1; I_cpu_data = 32'h1;
    I_dbg_req = 1'b0; I_dbg_we = 1'b0; I_dbg_addr = '0; I_dbg_wdata = '0; I_clr_req = 1'b0;
    repeat (2) @(posedge I_clk);
    @(negedge I_clk); #1;
    n_checks++;
    if (O_rf_we !== 1'b0 || O_rf_re !== 1'b0 || O_cpu_stall !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_gating: we=%b re=%b stall=%b expected 0 0 1", O_rf_we, O_rf_re, O_cpu_stall);
    end
    n_checks++;
    if (O_dbg_ack !== 1'b0 || O_dbg_rdata !== '0 || O_clr_busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: ack=%b rdata=%h busy=%b expected 0 0 0", O_dbg_ack, O_dbg_rdata, O_clr_busy);
    end
    I_reset = 1'b0; I_cpu_re = 1'b0; I_cpu_we = 1'b0;
    @(negedge I_clk); #1;
    n_checks++;
    if (O_cpu_stall !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL idle_after_reset: stall=%b expected 0", O_cpu_stall);
    end
  endtask

  task automatic test_cpu_path();
    @(negedge I_clk);
    I_cpu_we = 1'b1; I_cpu_rd = 5'd5; I_cpu_data = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (O_rf_we !== 1'b1 || O_rf_rd !== 5'd5 || O_rf_data !== 32'hDEADBEEF || O_cpu_stall !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL cpu_passthrough: we=%b rd=%0d data=%h stall=%b expected 1 5 deadbeef 0",
               O_rf_we, O_rf_rd, O_rf_data, O_cpu_stall);
    end
    @(posedge I_clk); #1;
    I_cpu_we = 1'b0;
    shadow[5] = 32'hDEADBEEF;
    cpu_read(5'd5);
  endtask

  task automatic test_debug();
    dbg_access(1'b1, 5'd7, 32'h12345678, 1);
    dbg_access(1'b0, 5'd7, '0, 2);
    dbg_access(1'b1, 5'd0, 32'hFFFF_FFFF, 1);
    n_checks++;
    if (O_dbg_rdata !== 32'h12345678) begin
      n_fail++;
      $display("[TB] FAIL dbg_rdata_hold: got %h expected 12345678", O_dbg_rdata);
    end
    dbg_access(1'b0, 5'd0, '0, 2);
  endtask

  task automatic test_arbitration();
    int acks = 0, run = 0, max_run = 0;
    bit cpu_pending = 1'b0;
    logic [W-1:0] exp;
    dbg_q.push_back(shadow[7]);
    for (int c = 0; c < 60 && acks < 4; c++) begin
      @(negedge I_clk);
      I_cpu_re = 1'b1; I_cpu_we = 1'b0; I_cpu_rs1 = 5'd5; I_cpu_rs2 = 5'd5;
      I_dbg_req = 1'b1; I_dbg_we = 1'b0; I_dbg_addr = 5'd7;
      #1;
      if (cpu_pending) begin
        exp = cpu_q.pop_front(); cpu_pending = 1'b0;
        n_checks++;
        if (I_rf_regval1 !== exp) begin
          n_fail++;
          $display("[TB] FAIL arb_cpu_data: got %h expected %h", I_rf_regval1, exp);
        end
      end
      if (O_dbg_ack) begin
        exp = dbg_q.pop_front(); acks++;
        n_checks++;
        if (O_dbg_rdata !== exp) begin
          n_fail++;
          $display("[TB] FAIL arb_dbg_data: got %h expected %h", O_dbg_rdata, exp);
        end
        if (acks < 4) dbg_q.push_back(shadow[7]);
        else I_dbg_req = 1'b0;
      end
      if (O_cpu_stall) run++;
      else begin
        run = 0; cpu_q.push_back(shadow[5]); cpu_pending = 1'b1;
      end
      if (run > max_run) max_run = run;
    end
    @(posedge I_clk); #1;
    I_cpu_re = 1'b0; I_dbg_req = 1'b0;
    if (cpu_pending) begin
      exp = cpu_q.pop_front();
      n_checks++;
      if (I_rf_regval1 !== exp) begin
        n_fail++;
        $display("[TB] FAIL arb_cpu_data_last: got %h expected %h", I_rf_regval1, exp);
      end
    end
    n_checks++;
    if (acks != 4 || max_run != 2) begin
      n_fail++;
      $display("[TB] FAIL arb_fairness: acks=%0d max_stall_run=%0d expected 4 2", acks, max_run);
    end
  endtask

  task automatic test_clear();
    int busy_cnt = 0;
    int idx = 1;
    for (int i = 1; i < 32; i++) cpu_write(5'(i), 32'hA500_0000 | 32'(i));
    @(negedge I_clk); I_clr_req = 1'b1;
    @(negedge I_clk); I_clr_req = 1'b0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (O_clr_busy) busy_cnt++;
      if (O_rf_we) begin
        n_checks++;
        if (O_rf_rd !== 5'(idx) || O_rf_data !== '0) begin
          n_fail++;
          $display("[TB] FAIL clear_sweep: rd=%0d data=%h expected %0d 0", O_rf_rd, O_rf_data, idx);
        end
        idx++;
      end
      if (!O_clr_busy && busy_cnt > 0) break;
      @(negedge I_clk);
    end
    n_checks++;
    if (busy_cnt != 32 || idx != 32) begin
      n_fail++;
      $display("[TB] FAIL clear_duration: busy=%0d writes=%0d expected 32 31", busy_cnt, idx - 1);
    end
    for (int i = 1; i < 32; i++) shadow[i] = '0;
    for (int i = 0; i < 32; i++) cpu_read(5'(i));
  endtask

  task automatic test_clr_during_dbg_read();
    cpu_write(5'd3, 32'h0000_0033);
    @(negedge I_clk);
    I_dbg_req = 1'b1; I_dbg_we = 1'b0; I_dbg_addr = 5'd3;
    @(negedge I_clk); I_clr_req = 1'b1;
    @(negedge I_clk); I_clr_req = 1'b0; #1;
    n_checks++;
    if (O_dbg_ack !== 1'b1 || O_dbg_rdata !== 32'h33 || O_clr_busy !== 1'b1 || O_rf_we !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL clr_after_dbg_ack: ack=%b rdata=%h busy=%b we=%b expected 1 33 1 0",
               O_dbg_ack, O_dbg_rdata, O_clr_busy, O_rf_we);
    end
    I_dbg_req = 1'b0;
    @(negedge I_clk); #1;
    n_checks++;
    if (O_rf_we !== 1'b1 || O_rf_rd !== 5'd1 || O_clr_busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL clr_start: we=%b rd=%0d busy=%b expected 1 1 1", O_rf_we, O_rf_rd, O_clr_busy);
    end
    for (int c = 0; c < 60 && O_clr_busy; c++) begin
      @(negedge I_clk); #1;
    end
    n_checks++;
    if (O_clr_busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL clr_finish: busy=%b expected 0", O_clr_busy);
    end
    for (int i = 1; i < 32; i++) shadow[i] = '0;
  endtask

  task automatic test_reset_mid_clear();
    bit found = 1'b0;
    for (int i = 9; i < 32; i++) cpu_write(5'(i), 32'hC0DE_0000 | 32'(i));
    @(negedge I_clk); I_clr_req = 1'b1;
    @(negedge I_clk); I_clr_req = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      #1;
      if (O_rf_we && O_rf_rd == 5'd9) found = 1'b1;
      else @(negedge I_clk);
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("[TB] FAIL rst_clear_reach9: clear never reached x9");
    end
    @(negedge I_clk); I_reset = 1'b1; #1;
    n_checks++;
    if (O_rf_we !== 1'b0 || O_cpu_stall !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_clear_gate: we=%b stall=%b expected 0 1", O_rf_we, O_cpu_stall);
    end
    @(negedge I_clk); I_reset = 1'b0; #1;
    n_checks++;
    if (O_clr_busy !== 1'b0 || O_rf_we !== 1'b0 || O_cpu_stall !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_clear_idle: busy=%b we=%b stall=%b expected 0 0 0",
               O_clr_busy, O_rf_we, O_cpu_stall);
    end
    for (int i = 1; i < 10; i++) shadow[i] = '0;
    cpu_read(5'd9);
    cpu_read(5'd10);
    cpu_read(5'd11);
    cpu_read(5'd31);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    test_reset();
    test_cpu_path();
    test_debug();
    test_arbitration();
    test_clear();
    test_clr_during_dbg_read();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
